// File: rtl/dac_stream_tx.sv
// ============================================================================
// dac_stream_tx : sample FIFO feeding a 16-bit SPI DAC frame serialiser
// Rev 1.0
// ============================================================================
`default_nettype none

module dac_stream_tx #(
  parameter int               DATA_W     = 12,
  parameter int               CMD_W      = 4,
  parameter logic [CMD_W-1:0] CMD        = 4'b0011,
  parameter int               FIFO_DEPTH = 8,
  parameter int               CLK_DIV    = 4,
  parameter int               GAP_CYC    = 8
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            wr_in,
  input  logic [DATA_W-1:0]               x_in,
  input  logic                            en_in,
  output logic                            full_out,
  output logic                            empty_out,
  output logic [$clog2(FIFO_DEPTH):0]     level_out,
  output logic                            ovf_out,
  output logic                            busy_out,
  output logic                            done_out,
  output logic                            dac_csn_out,
  output logic                            dac_sclk_out,
  output logic                            dac_mosi_out
);

  localparam int FRAME_W = CMD_W + DATA_W;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int DIV_W   = $clog2(2 * CLK_DIV);
  localparam int BIT_W   = $clog2(FRAME_W);
  localparam int GAP_W   = $clog2(GAP_CYC + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

  state_t             state_q,  state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q,  level_d;
  logic               full_q,   full_d;
  logic               empty_q,  empty_d;
  logic               ovf_q,    ovf_d;
  logic               busy_q,   busy_d;
  logic               done_q,   done_d;
  logic               csn_q,    csn_d;
  logic               sclk_q,   sclk_d;
  logic               mosi_q,   mosi_d;
  logic [FRAME_W-1:0] shreg_q,  shreg_d;
  logic [DIV_W-1:0]   div_q,    div_d;
  logic [BIT_W-1:0]   bit_q,    bit_d;
  logic [GAP_W-1:0]   gap_q,    gap_d;

  logic               pop;
  logic               push;
  logic [DIV_W-1:0]   div_inc;

  // A full FIFO still accepts a write in the LOAD cycle because the pop frees a slot.
  always_comb begin
    pop      = (state_q == S_LOAD);
    push     = wr_in && ((level_q != LVL_FULL) || pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    full_d  = (level_d == LVL_FULL);
    empty_d = (level_d == '0);
    ovf_d   = ovf_q | (wr_in & ~push);
  end

  always_comb begin
    state_d = state_q;
    csn_d   = csn_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    shreg_d = shreg_q;
    div_d   = div_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    done_d  = 1'b0;
    div_inc = div_q + DIV_W'(1);
    case (state_q)
      S_IDLE: begin
        csn_d  = 1'b1;
        sclk_d = 1'b0;
        if (en_in && !empty_q) state_d = S_LOAD;
      end
      S_LOAD: begin
        shreg_d = {CMD, mem_q[rd_ptr_q]};
        mosi_d  = CMD[CMD_W-1];
        csn_d   = 1'b0;
        sclk_d  = 1'b0;
        div_d   = '0;
        bit_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (div_q == DIV_LAST) begin
          // End of a bit: sclk falls and mosi moves to the next bit together.
          div_d  = '0;
          sclk_d = 1'b0;
          if (bit_q == BIT_LAST) begin
            csn_d   = 1'b1;
            mosi_d  = 1'b0;
            done_d  = 1'b1;
            gap_d   = '0;
            state_d = S_GAP;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
            mosi_d  = shreg_q[FRAME_W-2];
          end
        end else begin
          div_d  = div_inc;
          sclk_d = (div_inc >= DIV_HALF);
        end
      end
      S_GAP: begin
        csn_d  = 1'b1;
        sclk_d = 1'b0;
        if (gap_q == GAP_LAST) state_d = S_IDLE;
        else                   gap_d   = gap_q + GAP_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_ptr_q] <= x_in;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      csn_q    <= 1'b1;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      shreg_q  <= '0;
      div_q    <= '0;
      bit_q    <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      csn_q    <= csn_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      shreg_q  <= shreg_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      gap_q    <= gap_d;
    end
  end

  assign full_out     = full_q;
  assign empty_out    = empty_q;
  assign level_out    = level_q;
  assign ovf_out      = ovf_q;
  assign busy_out     = busy_q;
  assign done_out     = done_q;
  assign dac_csn_out  = csn_q;
  assign dac_sclk_out = sclk_q;
  assign dac_mosi_out = mosi_q;

endmodule

`default_nettype wire

// File: tb/tb_dac_stream_tx.sv
// ============================================================================
// tb_dac_stream_tx : directed self-checking bench for dac_stream_tx
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dac_stream_tx;

  localparam int CLK_DIV    = 2;
  localparam int GAP_CYC    = 8;
  localparam int FIFO_DEPTH = 8;
  localparam int FRAME_LOW  = 2 * CLK_DIV * 16;
  // csn also stays high through the IDLE and LOAD cycles that follow GAP.
  localparam int CSN_HIGH   = GAP_CYC + 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr = 1'b0;
  logic        en = 1'b0;
  logic [11:0] x = '0;

  wire         full, empty, ovf, busy, done, csn, sclk, mosi;
  wire [3:0]   level;

  int checks = 0;
  int errors = 0;

  dac_stream_tx #(
    .DATA_W(12), .CMD_W(4), .CMD(4'b0011),
    .FIFO_DEPTH(FIFO_DEPTH), .CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC)
  ) dut (
    .clk_in(clk), .rst_in(rst_n), .wr_in(wr), .x_in(x), .en_in(en),
    .full_out(full), .empty_out(empty), .level_out(level), .ovf_out(ovf),
    .busy_out(busy), .done_out(done), .dac_csn_out(csn),
    .dac_sclk_out(sclk), .dac_mosi_out(mosi)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_sample(input logic [11:0] v);
    @(negedge clk);
    wr = 1'b1;
    x  = v;
    @(negedge clk);
    wr = 1'b0;
  endtask

  // Returns at the first negedge with csn high after the frame.
  task automatic capture_frame(output logic [15:0] frame, output int low,
                               output int rises, output int dones, output int started);
    int   t;
    logic prev;
    frame = '0; low = 0; rises = 0; dones = 0; t = 0; prev = 1'b0;
    while (csn === 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    started = (csn === 1'b0) ? 1 : 0;
    while (csn === 1'b0 && low < 200) begin
      if (sclk && !prev) begin
        frame = {frame[14:0], mosi};
        rises++;
      end
      prev = sclk;
      if (done) dones++;
      low++;
      @(negedge clk);
    end
    if (done) dones++;
  endtask

  task automatic measure_gap(output int hi);
    hi = 0;
    while (csn === 1'b1 && hi < 200) begin
      hi++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] frame;
    int low, rises, dones, started, hi, lowcnt;

    // 1: reset held with traffic on the inputs
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wr = 1'b1;
      x  = 12'(i + 5);
    end
    @(negedge clk);
    check_eq("rst_csn",   csn,   1);
    check_eq("rst_sclk",  sclk,  0);
    check_eq("rst_mosi",  mosi,  0);
    check_eq("rst_empty", empty, 1);
    check_eq("rst_full",  full,  0);
    check_eq("rst_level", level, 0);
    check_eq("rst_ovf",   ovf,   0);
    check_eq("rst_busy",  busy,  0);
    check_eq("rst_done",  done,  0);
    wr = 1'b0;
    rst_n = 1'b1;

    // 2: single frame carrying 0xABC
    push_sample(12'hABC);
    capture_frame(frame, low, rises, dones, started);
    check_eq("t2_started", started, 1);
    check_eq("t2_frame",   frame,   16'h3ABC);
    check_eq("t2_csn_low", low,     FRAME_LOW);
    check_eq("t2_rises",   rises,   16);
    check_eq("t2_done",    dones,   1);
    repeat (GAP_CYC + 2) @(negedge clk);
    check_eq("t2_empty", empty, 1);
    check_eq("t2_level", level, 0);
    check_eq("t2_busy",  busy,  0);

    // 3: fill with en low, ninth write overflows
    en = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      push_sample(12'(i));
      check_eq("t3_level", level, 32'(i));
      check_eq("t3_full",  full,  (i == 8) ? 1 : 0);
    end
    check_eq("t3_ovf_before", ovf, 0);
    push_sample(12'd9);
    check_eq("t3_ovf_after", ovf,   1);
    check_eq("t3_level9",    level, 8);
    check_eq("t3_full9",     full,  1);

    // 4: drain eight frames in order
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      capture_frame(frame, low, rises, dones, started);
      check_eq("t4_started", started, 1);
      check_eq("t4_frame",   frame,   32'h3000 + 32'(i + 1));
      check_eq("t4_csn_low", low,     FRAME_LOW);
      check_eq("t4_done",    dones,   1);
      if (i < 7) begin
        measure_gap(hi);
        check_eq("t4_csn_high", hi, CSN_HIGH);
      end
    end
    @(negedge clk);
    check_eq("t4_empty", empty, 1);
    check_eq("t4_ovf",   ovf,   1);
    repeat (GAP_CYC + 4) @(negedge clk);

    // 5: write into a full FIFO during the LOAD cycle
    en = 1'b0;
    do_reset();
    check_eq("t5_ovf_rst", ovf, 0);
    for (int i = 0; i < 8; i++) push_sample(12'h10 + 12'(i));
    check_eq("t5_level_full", level, 8);
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    check_eq("t5_busy_load", busy, 1);
    check_eq("t5_csn_load",  csn,  1);
    wr = 1'b1;
    x  = 12'h055;
    @(negedge clk);
    wr = 1'b0;
    check_eq("t5_level", level, 8);
    check_eq("t5_full",  full,  1);
    check_eq("t5_ovf",   ovf,   0);
    for (int i = 0; i < 9; i++) begin
      capture_frame(frame, low, rises, dones, started);
      check_eq("t5_frame", frame, (i < 8) ? (32'h3010 + 32'(i)) : 32'h3055);
    end
    repeat (GAP_CYC + 4) @(negedge clk);

    // 6: asynchronous reset mid-frame
    en = 1'b0;
    for (int i = 0; i < 4; i++) push_sample(12'h21 + 12'(i));
    en = 1'b1;
    capture_frame(frame, low, rises, dones, started);
    // capture ran a full frame; now abort the next one part-way
    rises = 0;
    begin
      logic prev;
      int   t;
      prev = 1'b0;
      t = 0;
      while (csn === 1'b1 && t < 500) begin
        @(negedge clk);
        t++;
      end
      check_eq("t6_started", csn, 0);
      t = 0;
      while (rises < 7 && t < 500) begin
        if (sclk && !prev) rises++;
        prev = sclk;
        @(negedge clk);
        t++;
      end
      check_eq("t6_rises", rises, 7);
    end
    check_eq("t6_level_pre", level, 2);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_csn",   csn,   1);
    check_eq("t6_sclk",  sclk,  0);
    check_eq("t6_mosi",  mosi,  0);
    check_eq("t6_level", level, 0);
    check_eq("t6_empty", empty, 1);
    check_eq("t6_busy",  busy,  0);
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    lowcnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (csn !== 1'b1) lowcnt++;
    end
    check_eq("t6_no_frame", lowcnt, 0);
    check_eq("t6_busy_after", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
